// File: rtl/stack_pkg.sv
// Shared definitions for the stack unit: selector encodings and FSM states.
// Selector encodings must track the upstream stack selection logic.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    SEL_NOP  = 2'b00,
    SEL_ALU  = 2'b01,
    SEL_PUSH = 2'b10,
    SEL_POP  = 2'b11
  } sel_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/stack_unit_if.sv
// Operation/status bundle between the stack selection logic (master) and
// the stack unit (slave).
interface stack_unit_if
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             sel_valid;
  logic [1:0]       selector;
  logic [WIDTH-1:0] data_in;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [CNT_W-1:0] depth;
  logic             empty;
  logic             full;
  logic             overflow_err;
  logic             underflow_err;
  logic             fault;

  modport master (
    output sel_valid, selector, data_in, err_clr,
    input  data_out, out_valid, depth, empty, full,
           overflow_err, underflow_err, fault
  );

  modport slave (
    input  sel_valid, selector, data_in, err_clr,
    output data_out, out_valid, depth, empty, full,
           overflow_err, underflow_err, fault
  );

endinterface

// File: rtl/stack_mem.sv
// DEPTH x WIDTH stack storage: one synchronous write port, one
// combinational read port (driven with the top-of-stack index).
module stack_mem
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack executing the selected NOP / ALU write-back / PUSH / POP
// operation, with sticky overflow/underflow faults.
//
// state    | meaning
// ST_RUN   | operations accepted on sel_valid
// ST_FAULT | illegal op seen; ops ignored, state frozen until err_clr
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  stack_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  state_e           state, state_nxt;
  sel_e             sel;
  logic [CNT_W-1:0] depth_q;
  logic [WIDTH-1:0] data_out_q;
  logic             out_valid_q;
  logic             ovf_q, unf_q;
  logic             empty_w, full_w;
  logic             push_ok, pop_ok, wb_ok, push_bad, unf_bad, clr_go;
  logic             mem_we;
  logic [AW-1:0]    top_idx, push_idx, mem_waddr;
  logic [WIDTH-1:0] top_data;

  assign sel      = sel_e'(bus.selector);
  assign empty_w  = (depth_q == '0);
  assign full_w   = (depth_q == CNT_W'(DEPTH));
  assign top_idx  = AW'(depth_q - CNT_W'(1));
  assign push_idx = AW'(depth_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (push_bad || unf_bad) state_nxt = ST_FAULT;
      ST_FAULT: if (bus.err_clr)         state_nxt = ST_RUN;
      default:                           state_nxt = ST_RUN;
    endcase
  end

  // Operation decode; everything is gated off outside RUN.
  always_comb begin
    push_ok  = 1'b0;
    pop_ok   = 1'b0;
    wb_ok    = 1'b0;
    push_bad = 1'b0;
    unf_bad  = 1'b0;
    clr_go   = (state == ST_FAULT) && bus.err_clr;
    if (state == ST_RUN && bus.sel_valid) begin
      case (sel)
        SEL_PUSH: begin
          push_ok  = !full_w;
          push_bad = full_w;
        end
        SEL_POP: begin
          pop_ok  = !empty_w;
          unf_bad = empty_w;
        end
        SEL_ALU: begin
          wb_ok   = !empty_w;
          unf_bad = empty_w;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      out_valid_q <= pop_ok || wb_ok;
      if (push_ok)     depth_q <= depth_q + CNT_W'(1);
      else if (pop_ok) depth_q <= depth_q - CNT_W'(1);
      if (pop_ok)      data_out_q <= top_data;
      else if (wb_ok)  data_out_q <= bus.data_in;
      if (clr_go) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (push_bad) ovf_q <= 1'b1;
        if (unf_bad)  unf_q <= 1'b1;
      end
    end
  end

  // Write is squashed during reset so a same-cycle push leaves no trace.
  assign mem_we    = rst_n && (push_ok || wb_ok);
  assign mem_waddr = push_ok ? push_idx : top_idx;

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (bus.data_in),
    .rd_addr (top_idx),
    .rd_data (top_data)
  );

  assign bus.data_out      = data_out_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.depth         = depth_q;
  assign bus.empty         = empty_w;
  assign bus.full          = full_w;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
  assign bus.fault         = (state == ST_FAULT);

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: reset, LIFO order, overflow/underflow
// faults, idle cycles and reset during an operation.
module tb_stack_unit;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  stack_unit_if #(.WIDTH(8), .DEPTH(8)) bus ();

  stack_unit #(.WIDTH(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] s, input logic [7:0] d);
    bus.sel_valid = 1'b1;
    bus.selector  = s;
    bus.data_in   = d;
    step();
    bus.sel_valid = 1'b0;
    bus.selector  = SEL_NOP;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.depth !== 4'd0) begin tests_failed++; $display("FAIL reset_depth: got %0d expected 0", bus.depth); end
    tests_run++;
    if ({bus.empty, bus.full} !== 2'b10) begin tests_failed++; $display("FAIL reset_empty_full: got %b expected 10", {bus.empty, bus.full}); end
    tests_run++;
    if (bus.data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
    tests_run++;
    if ({bus.overflow_err, bus.underflow_err, bus.fault, bus.out_valid} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 0000",
        {bus.overflow_err, bus.underflow_err, bus.fault, bus.out_valid});
    end
  endtask

  task automatic test_lifo();
    logic [7:0] exp_data [3];
    exp_data = '{8'h33, 8'h22, 8'h11};
    op(SEL_PUSH, 8'h11);
    op(SEL_PUSH, 8'h22);
    op(SEL_PUSH, 8'h33);
    tests_run++;
    if (bus.depth !== 4'd3) begin tests_failed++; $display("FAIL lifo_depth3: got %0d expected 3", bus.depth); end
    for (int i = 0; i < 3; i++) begin
      op(SEL_POP, 8'h00);
      tests_run++;
      if (bus.data_out !== exp_data[i] || bus.out_valid !== 1'b1 || bus.depth !== 4'(2 - i)) begin
        tests_failed++;
        $display("FAIL lifo_pop%0d: got data %h valid %b depth %0d expected data %h valid 1 depth %0d",
                 i, bus.data_out, bus.out_valid, bus.depth, exp_data[i], 2 - i);
      end
    end
    tests_run++;
    if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL lifo_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) op(SEL_PUSH, 8'(i));
    tests_run++;
    if (bus.full !== 1'b1 || bus.depth !== 4'd8) begin tests_failed++; $display("FAIL ovf_full: got full %b depth %0d expected full 1 depth 8", bus.full, bus.depth); end
    op(SEL_PUSH, 8'hFF);
    tests_run++;
    if ({bus.overflow_err, bus.fault, bus.underflow_err} !== 3'b110 || bus.depth !== 4'd8) begin
      tests_failed++; $display("FAIL ovf_flag: got ovf/fault/unf %b depth %0d expected 110 depth 8",
        {bus.overflow_err, bus.fault, bus.underflow_err}, bus.depth);
    end
    op(SEL_POP, 8'h00);
    tests_run++;
    if (bus.depth !== 4'd8 || bus.data_out !== 8'h11 || bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_pop_ignored: got depth %0d data %h valid %b expected depth 8 data 11 valid 0",
        bus.depth, bus.data_out, bus.out_valid);
    end
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    tests_run++;
    if ({bus.fault, bus.overflow_err} !== 2'b00) begin tests_failed++; $display("FAIL ovf_clear: got fault/ovf %b expected 00", {bus.fault, bus.overflow_err}); end
    op(SEL_POP, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h08 || bus.out_valid !== 1'b1 || bus.depth !== 4'd7 || bus.full !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_pop_after_clr: got data %h valid %b depth %0d full %b expected data 08 valid 1 depth 7 full 0",
        bus.data_out, bus.out_valid, bus.depth, bus.full);
    end
    op(SEL_PUSH, 8'h99);
    tests_run++;
    if (bus.full !== 1'b1 || bus.depth !== 4'd8) begin tests_failed++; $display("FAIL alt_full_push: got full %b depth %0d expected full 1 depth 8", bus.full, bus.depth); end
    op(SEL_POP, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h99 || bus.full !== 1'b0 || bus.depth !== 4'd7 || bus.overflow_err !== 1'b0) begin
      tests_failed++; $display("FAIL alt_full_pop: got data %h full %b depth %0d ovf %b expected data 99 full 0 depth 7 ovf 0",
        bus.data_out, bus.full, bus.depth, bus.overflow_err);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    op(SEL_ALU, 8'hAA);
    tests_run++;
    if ({bus.underflow_err, bus.fault, bus.overflow_err, bus.out_valid} !== 4'b1100 || bus.data_out !== 8'h00) begin
      tests_failed++; $display("FAIL unf_flag: got unf/fault/ovf/valid %b data %h expected 1100 data 00",
        {bus.underflow_err, bus.fault, bus.overflow_err, bus.out_valid}, bus.data_out);
    end
    bus.err_clr = 1'b1;
    op(SEL_PUSH, 8'h33);
    bus.err_clr = 1'b0;
    tests_run++;
    if ({bus.fault, bus.underflow_err} !== 2'b00 || bus.depth !== 4'd0) begin
      tests_failed++; $display("FAIL unf_clear_priority: got fault/unf %b depth %0d expected 00 depth 0",
        {bus.fault, bus.underflow_err}, bus.depth);
    end
    op(SEL_PUSH, 8'h10);
    op(SEL_ALU, 8'h5A);
    tests_run++;
    if (bus.data_out !== 8'h5A || bus.out_valid !== 1'b1 || bus.depth !== 4'd1) begin
      tests_failed++; $display("FAIL wb: got data %h valid %b depth %0d expected data 5a valid 1 depth 1",
        bus.data_out, bus.out_valid, bus.depth);
    end
    op(SEL_PUSH, 8'h66);
    op(SEL_POP, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h66 || bus.depth !== 4'd1 || bus.empty !== 1'b0) begin
      tests_failed++; $display("FAIL alt_empty_pop: got data %h depth %0d empty %b expected data 66 depth 1 empty 0",
        bus.data_out, bus.depth, bus.empty);
    end
    op(SEL_POP, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h5A || bus.depth !== 4'd0 || bus.empty !== 1'b1 || bus.underflow_err !== 1'b0) begin
      tests_failed++; $display("FAIL wb_pop: got data %h depth %0d empty %b unf %b expected data 5a depth 0 empty 1 unf 0",
        bus.data_out, bus.depth, bus.empty, bus.underflow_err);
    end
  endtask

  task automatic test_idle();
    op(SEL_PUSH, 8'h44);
    bus.sel_valid = 1'b0;
    bus.selector  = SEL_PUSH;
    bus.data_in   = 8'h77;
    step();
    step();
    step();
    tests_run++;
    if (bus.depth !== 4'd1 || bus.data_out !== 8'h5A || bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_invalid: got depth %0d data %h valid %b expected depth 1 data 5a valid 0",
        bus.depth, bus.data_out, bus.out_valid);
    end
    op(SEL_NOP, 8'h77);
    tests_run++;
    if (bus.depth !== 4'd1 || bus.data_out !== 8'h5A || bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_nop: got depth %0d data %h valid %b expected depth 1 data 5a valid 0",
        bus.depth, bus.data_out, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 1; i <= 4; i++) op(SEL_PUSH, 8'(i));
    tests_run++;
    if (bus.depth !== 4'd4) begin tests_failed++; $display("FAIL mid_depth4: got %0d expected 4", bus.depth); end
    rst_n = 1'b0;
    op(SEL_PUSH, 8'h55);
    rst_n = 1'b1;
    tests_run++;
    if (bus.depth !== 4'd0 || {bus.overflow_err, bus.underflow_err, bus.fault} !== 3'b000 || bus.data_out !== 8'h00) begin
      tests_failed++; $display("FAIL mid_reset: got depth %0d flags %b data %h expected depth 0 flags 000 data 00",
        bus.depth, {bus.overflow_err, bus.underflow_err, bus.fault}, bus.data_out);
    end
    bus.err_clr = 1'b1;
    op(SEL_PUSH, 8'h09);
    bus.err_clr = 1'b0;
    tests_run++;
    if (bus.depth !== 4'd1) begin tests_failed++; $display("FAIL clr_in_run_push: got depth %0d expected 1", bus.depth); end
    op(SEL_POP, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h09 || bus.depth !== 4'd0 || bus.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL mid_pop: got data %h depth %0d valid %b expected data 09 depth 0 valid 1",
        bus.data_out, bus.depth, bus.out_valid);
    end
  endtask

  initial begin
    bus.sel_valid = 1'b0;
    bus.selector  = SEL_NOP;
    bus.data_in   = 8'h00;
    bus.err_clr   = 1'b0;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_idle();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
